ioc_bus_master: RTL and testbench

- Sequences the shared IOC register bus (cs / fetch / load / ioc / data) between the host byte link (SPI slave) and up to NUM_MODULES control modules (sys_ctrl, io_ctrl, smi_ctrl, ...).
- Decodes a host command byte and, for writes, collects the data byte.
- Drives exactly one module's chip-select with a single fetch or load strobe.
- For reads, captures the module's registered reply and returns it to the host.
- Latches sticky error flags that feed the sys_ctrl error list.

---
 rtl/ioc_bus_pkg.sv | 44 ++++
 rtl/ioc_bus_master.sv | 206 ++++++++++++++++++++
 tb/tb_ioc_bus_master.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ioc_bus_pkg.sv
// ioc_bus_pkg
// Shared definitions for the IOC register-bus master: FSM state encoding,
// host command-byte field positions, sticky error bit indices, well-known
// module slots and the value returned when a read targets a missing module.
package ioc_bus_pkg;

  // Bus sequencer states. The encoding is also exported on the master's
  // debug state output.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DATA    = 3'd1,
    ST_LOAD    = 3'd2,
    ST_FETCH   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_SEND    = 3'd5,
    ST_RELEASE = 3'd6
  } state_e;

  // Command byte layout: [7] direction (1 = write/load), [6:5] module, [4:0] ioc.
  localparam int DIR_BIT = 7;
  localparam int MOD_MSB = 6;
  localparam int MOD_LSB = 5;
  localparam int IOC_W   = 5;

  // Sticky error flag bit positions.
  localparam int ERR_BAD_MOD = 0;
  localparam int ERR_OVERRUN = 1;
  localparam int ERR_TIMEOUT = 2;
  localparam int ERR_W       = 3;

  // Module slots on the bus.
  localparam logic [1:0] MOD_SYS = 2'd0;
  localparam logic [1:0] MOD_IO  = 2'd1;
  localparam logic [1:0] MOD_SMI = 2'd2;

  // Reply returned to the host when the addressed module does not exist.
  localparam logic [7:0] BAD_MOD_DATA = 8'hFF;

  // True when a module index has no module behind it.
  function automatic logic idx_is_bad(input logic [1:0] idx, input int num_modules);
    return (int'(idx) >= num_modules);
  endfunction

endpackage

// File: rtl/ioc_bus_master.sv
// ioc_bus_master
// Sequences the shared IOC register bus between the host byte link and up to
// NUM_MODULES control modules. A host command byte selects direction, module
// and register; writes collect one further data byte. Exactly one module
// select is driven with a single fetch or load strobe, a read reply is
// captured one cycle after the fetch and offered to the host, and every
// transaction ends with a release cycle so each module sees cs low.
//
// Handshake: o_tx_valid rises with o_tx_byte and both stay constant until a
// cycle in which i_tx_ready is high; that cycle is the single transfer and
// o_tx_valid is low on the following cycle. i_rx_valid is a one-cycle strobe
// with no back-pressure; bytes arriving outside IDLE/DATA are dropped.
//
// Optional build macro: IOC_BUS_TIMEOUT_EN -- bounds the wait for a write
// data byte to TIMEOUT_CYCLES cycles and drives o_err_flags[2]. When the
// macro is undefined the data wait is unbounded and o_err_flags[2] is 0.
//
// Ports:
//   i_sys_clk, i_reset_n        clock, asynchronous active-low reset
//   i_rx_byte, i_rx_valid       byte strobe from host link
//   o_tx_byte, o_tx_valid,
//   i_tx_ready                  read reply to host link (valid/ready)
//   o_cs                        one-hot module select
//   o_ioc, o_data               register index and write data
//   o_fetch_cmd, o_load_cmd     read / write strobes (one cycle each)
//   i_mod_data                  module k read data at [8k+7:8k]
//   o_busy                      high whenever the sequencer is not idle
//   o_err_flags, i_err_clear    sticky [0] bad module, [1] overrun,
//                               [2] timeout; synchronous clear (set wins)
//   o_state_dbg                 current sequencer state
module ioc_bus_master
  import ioc_bus_pkg::*;
#(
  parameter int NUM_MODULES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     i_sys_clk,
  input  logic                     i_reset_n,
  input  logic [7:0]               i_rx_byte,
  input  logic                     i_rx_valid,
  output logic [7:0]               o_tx_byte,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [NUM_MODULES-1:0]   o_cs,
  output logic [IOC_W-1:0]         o_ioc,
  output logic [7:0]               o_data,
  output logic                     o_fetch_cmd,
  output logic                     o_load_cmd,
  input  logic [8*NUM_MODULES-1:0] i_mod_data,
  output logic                     o_busy,
  output logic [ERR_W-1:0]         o_err_flags,
  input  logic                     i_err_clear,
  output logic [2:0]               o_state_dbg
);

  if (NUM_MODULES < 1 || NUM_MODULES > 4) begin : g_bad_num_modules
    $error("ioc_bus_master: NUM_MODULES must be 1..4");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("ioc_bus_master: TIMEOUT_CYCLES must be at least 2");
  end

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [IOC_W-1:0]       ioc_q, ioc_d;
  logic [7:0]             data_q, data_d;
  logic [7:0]             tx_byte_q, tx_byte_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   fetch_q, fetch_d;
  logic                   load_q, load_d;
  logic                   busy_q, busy_d;
  logic [NUM_MODULES-1:0] cs_q, cs_d;
  logic [ERR_W-1:0]       err_q, err_d, err_set;
  logic [7:0]             mod_rd;
  logic                   timeout_hit;

  // Read-data mux. An index with no module behind it matches no slot and
  // falls through to the fixed bad-module reply.
  always_comb begin
    mod_rd = BAD_MOD_DATA;
    for (int k = 0; k < NUM_MODULES; k++) begin
      if (idx_q == 2'(k)) mod_rd = i_mod_data[8*k +: 8];
    end
  end

`ifdef IOC_BUS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;

  // Counts idle DATA cycles; it is zero in every other state, so it starts
  // from zero on each entry into DATA.
  always_comb begin
    tmo_d = '0;
    if (state_q == ST_DATA && !i_rx_valid) tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) tmo_q <= '0;
    else            tmo_q <= tmo_d;
  end

  assign timeout_hit = (state_q == ST_DATA) && !i_rx_valid &&
                       (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (i_rx_valid) state_d = i_rx_byte[DIR_BIT] ? ST_DATA : ST_FETCH;
      ST_DATA: begin
        if (i_rx_valid)       state_d = ST_LOAD;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_LOAD:    state_d = ST_RELEASE;
      ST_FETCH:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_SEND;
      ST_SEND:    if (i_tx_ready) state_d = ST_RELEASE;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values. Bus outputs are decoded from the state
  // being entered so that the registered outputs line up with state_q.
  always_comb begin
    ioc_d     = ioc_q;
    idx_d     = idx_q;
    data_d    = data_q;
    tx_byte_d = tx_byte_q;
    err_set   = '0;

    if (state_q == ST_IDLE && i_rx_valid) begin
      ioc_d = i_rx_byte[IOC_W-1:0];
      idx_d = i_rx_byte[MOD_MSB:MOD_LSB];
      err_set[ERR_BAD_MOD] = idx_is_bad(i_rx_byte[MOD_MSB:MOD_LSB], NUM_MODULES);
    end
    if (state_q == ST_DATA && i_rx_valid) data_d = i_rx_byte;
    if (state_q == ST_CAPTURE) tx_byte_d = mod_rd;

    if (i_rx_valid && state_q != ST_IDLE && state_q != ST_DATA) err_set[ERR_OVERRUN] = 1'b1;
    err_set[ERR_TIMEOUT] = timeout_hit;

    // A flag being set in the same cycle as a clear survives the clear.
    err_d = (i_err_clear ? {ERR_W{1'b0}} : err_q) | err_set;

    busy_d     = (state_d != ST_IDLE);
    fetch_d    = (state_d == ST_FETCH);
    load_d     = (state_d == ST_LOAD);
    tx_valid_d = (state_d == ST_SEND);

    // cs spans the strobe cycle and, for reads, the capture cycle. A bad
    // index matches no slot, so cs stays all-zero for it.
    cs_d = '0;
    if (state_d == ST_LOAD || state_d == ST_FETCH || state_d == ST_CAPTURE) begin
      for (int k = 0; k < NUM_MODULES; k++) cs_d[k] = (idx_d == 2'(k));
    end
  end

  // Output and datapath registers.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ioc_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      fetch_q    <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      cs_q       <= '0;
      err_q      <= '0;
    end else begin
      ioc_q      <= ioc_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      fetch_q    <= fetch_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      cs_q       <= cs_d;
      err_q      <= err_d;
    end
  end

  assign o_tx_byte   = tx_byte_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_cs        = cs_q;
  assign o_ioc       = ioc_q;
  assign o_data      = data_q;
  assign o_fetch_cmd = fetch_q;
  assign o_load_cmd  = load_q;
  assign o_busy      = busy_q;
  assign o_err_flags = err_q;
  assign o_state_dbg = state_q;

endmodule

// File: tb/tb_ioc_bus_master.sv
module tb_ioc_bus_master;
  import ioc_bus_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 16;

  // Transaction phases of the reference model (what the bus shows this cycle).
  localparam int P_IDLE  = 0;
  localparam int P_WAIT  = 1;
  localparam int P_LOAD  = 2;
  localparam int P_FETCH = 3;
  localparam int P_CAPT  = 4;
  localparam int P_SEND  = 5;
  localparam int P_REL   = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]     rx_byte = '0;
  logic           rx_valid = 1'b0;
  logic           tx_ready = 1'b1;
  logic           err_clear = 1'b0;
  logic [8*N-1:0] mod_data = '0;
  logic [7:0]     tx_byte;
  logic           tx_valid;
  logic [N-1:0]   cs;
  logic [4:0]     ioc;
  logic [7:0]     data;
  logic           fetch_cmd, load_cmd, busy;
  logic [2:0]     err_flags;
  logic [2:0]     state_dbg;

  ioc_bus_master #(.NUM_MODULES(N), .TIMEOUT_CYCLES(TMO)) dut (
    .i_sys_clk   (clk),
    .i_reset_n   (rst_n),
    .i_rx_byte   (rx_byte),
    .i_rx_valid  (rx_valid),
    .o_tx_byte   (tx_byte),
    .o_tx_valid  (tx_valid),
    .i_tx_ready  (tx_ready),
    .o_cs        (cs),
    .o_ioc       (ioc),
    .o_data      (data),
    .o_fetch_cmd (fetch_cmd),
    .o_load_cmd  (load_cmd),
    .i_mod_data  (mod_data),
    .o_busy      (busy),
    .o_err_flags (err_flags),
    .i_err_clear (err_clear),
    .o_state_dbg (state_dbg)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         ph_q[$];
  int         m_idx  = 0;
  int         m_wait = 0;
  logic [4:0] m_ioc  = '0;
  logic [7:0] m_data = '0;
  logic [7:0] m_tx   = '0;
  logic [2:0] m_err  = '0;

  always @(posedge clk or negedge rst_n) begin : model
    int cur;
    logic [2:0] set;
    if (!rst_n) begin
      ph_q.delete();
      m_idx = 0; m_wait = 0; m_ioc = '0; m_data = '0; m_tx = '0; m_err = '0;
    end else begin
      set = '0;
      cur = (ph_q.size() == 0) ? P_IDLE : ph_q[0];
      if (rx_valid && cur != P_IDLE && cur != P_WAIT) set[1] = 1'b1;
      case (cur)
        P_IDLE: if (rx_valid) begin
          m_ioc = rx_byte[4:0];
          m_idx = int'(rx_byte[6:5]);
          if (m_idx >= N) set[0] = 1'b1;
          if (rx_byte[7]) begin
            ph_q = '{P_WAIT};
            m_wait = 0;
          end else begin
            ph_q = '{P_FETCH, P_CAPT, P_SEND, P_REL};
          end
        end
        P_WAIT: begin
          if (rx_valid) begin
            m_data = rx_byte;
            ph_q = '{P_LOAD, P_REL};
          end else begin
`ifdef IOC_BUS_TIMEOUT_EN
            if (m_wait == TMO - 1) begin
              ph_q.delete();
              set[2] = 1'b1;
            end else begin
              m_wait++;
            end
`endif
          end
        end
        P_CAPT: begin
          if (m_idx < N) m_tx = mod_data[8*m_idx +: 8];
          else           m_tx = 8'hFF;
          void'(ph_q.pop_front());
        end
        P_SEND: if (tx_ready) void'(ph_q.pop_front());
        default: void'(ph_q.pop_front());
      endcase
      m_err = (err_clear ? 3'b000 : m_err) | set;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    int cur;
    logic [N-1:0] e_cs;
    if (rst_n) begin
      cur = (ph_q.size() == 0) ? P_IDLE : ph_q[0];
      e_cs = '0;
      if ((cur == P_LOAD || cur == P_FETCH || cur == P_CAPT) && m_idx < N) e_cs[m_idx] = 1'b1;
      chk("cyc_cs",    32'(cs),        32'(e_cs));
      chk("cyc_fetch", 32'(fetch_cmd), 32'(cur == P_FETCH));
      chk("cyc_load",  32'(load_cmd),  32'(cur == P_LOAD));
      chk("cyc_txv",   32'(tx_valid),  32'(cur == P_SEND));
      chk("cyc_busy",  32'(busy),      32'(cur != P_IDLE));
      chk("cyc_ioc",   32'(ioc),       32'(m_ioc));
      chk("cyc_data",  32'(data),      32'(m_data));
      chk("cyc_txb",   32'(tx_byte),   32'(m_tx));
      chk("cyc_err",   32'(err_flags), 32'(m_err));
    end
  end

  // ---------------- background random drivers ----------------
  logic rand_ready = 1'b0;
  logic rand_mod   = 1'b0;
  logic rand_clr   = 1'b0;

  always @(negedge clk) begin
    if (rand_ready) tx_ready = ($urandom_range(0, 1) == 1);
    if (rand_mod)   mod_data = (8*N)'($urandom);
    if (rand_clr)   err_clear = ($urandom_range(0, 15) == 0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_idle: still busy after %0d cycles at %0t", budget, $time);
    end
  endtask

  task automatic clear_errors();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("err_cleared", 32'(err_flags), 32'h0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    logic [7:0] cmd;
    repeat (3) tick();
    chk("rst_cs",    32'(cs), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_txv",   32'(tx_valid), 32'h0);
    chk("rst_strb",  32'({fetch_cmd, load_cmd}), 32'h0);
    chk("rst_err",   32'(err_flags), 32'h0);
    chk("rst_ioc",   32'(ioc), 32'h0);
    rst_n = 1'b1;
    tick();

    // Write: sys_ctrl soft reset.
    tx_ready = 1'b1;
    send_byte({1'b1, MOD_SYS, 5'h04});
    chk("wr_wait_busy", 32'(busy), 32'h1);
    chk("wr_wait_ioc",  32'(ioc), 32'h04);
    chk("wr_wait_cs",   32'(cs), 32'h0);
    send_byte(8'h00);
    chk("wr_load",      32'(load_cmd), 32'h1);
    chk("wr_cs",        32'(cs), 32'b001);
    chk("wr_data",      32'(data), 32'h00);
    tick();
    chk("wr_load_once", 32'(load_cmd), 32'h0);
    chk("wr_rel_cs",    32'(cs), 32'h0);
    chk("wr_rel_busy",  32'(busy), 32'h1);
    tick();
    chk("wr_idle",      32'(busy), 32'h0);

    // Read from module 0 with ready high.
    mod_data = {8'h00, 8'h00, 8'h5A};
    send_byte({1'b0, MOD_SYS, 5'h03});
    chk("rd_fetch",     32'(fetch_cmd), 32'h1);
    chk("rd_fetch_cs",  32'(cs), 32'b001);
    tick();
    chk("rd_capt_fetch", 32'(fetch_cmd), 32'h0);
    chk("rd_capt_cs",   32'(cs), 32'b001);
    tick();
    chk("rd_txv",       32'(tx_valid), 32'h1);
    chk("rd_txb",       32'(tx_byte), 32'h5A);
    chk("rd_send_cs",   32'(cs), 32'h0);
    tick();
    chk("rd_txv_drop",  32'(tx_valid), 32'h0);
    tick();
    tick();
    chk("rd_idle_t6",   32'(busy), 32'h0);

    // Backpressure: ready low for 10 cycles of SEND.
    tx_ready = 1'b0;
    mod_data = {8'h00, 8'hC3, 8'h00};
    send_byte({1'b0, MOD_IO, 5'h01});
    tick();
    tick();
    mod_data = {8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 10; i++) begin
      chk("bp_txv", 32'(tx_valid), 32'h1);
      chk("bp_txb", 32'(tx_byte), 32'hC3);
      tick();
    end
    tx_ready = 1'b1;
    tick();
    chk("bp_handoff", 32'(tx_valid), 32'h0);
    wait_idle(10);

    // Bad module read (index 3 with three modules).
    mod_data = 24'h123456;
    send_byte(8'h60);
    chk("bad_fetch_cs", 32'(cs), 32'h0);
    chk("bad_err",      32'(err_flags), 32'b001);
    tick();
    chk("bad_capt_cs",  32'(cs), 32'h0);
    tick();
    chk("bad_txb",      32'(tx_byte), 32'hFF);
    wait_idle(10);
    chk("bad_err_hold", 32'(err_flags), 32'b001);
    clear_errors();

    // Overrun: byte strobe during SEND is dropped.
    tx_ready = 1'b0;
    mod_data = {8'h9C, 8'h00, 8'h00};
    send_byte({1'b0, MOD_SMI, 5'h02});
    tick();
    tick();
    send_byte(8'hEE);
    chk("ovr_err",  32'(err_flags), 32'b010);
    chk("ovr_txv",  32'(tx_valid), 32'h1);
    chk("ovr_txb",  32'(tx_byte), 32'h9C);
    tx_ready = 1'b1;
    wait_idle(10);
    chk("ovr_ioc",  32'(ioc), 32'h02);
    chk("ovr_data", 32'(data), 32'h00);
    clear_errors();

`ifdef IOC_BUS_TIMEOUT_EN
    // Timeout: command 8'hA1, no data byte.
    send_byte(8'hA1);
    for (int i = 0; i < TMO - 1; i++) tick();
    chk("tmo_last_wait", 32'(busy), 32'h1);
    tick();
    chk("tmo_idle",  32'(busy), 32'h0);
    chk("tmo_err",   32'(err_flags), 32'b100);
    chk("tmo_noload", 32'(load_cmd), 32'h0);
    clear_errors();
`endif

    // Reset asserted in the middle of a LOAD cycle.
    send_byte({1'b1, MOD_SYS, 5'h05});
    send_byte(8'h11);
    chk("rl_load", 32'(load_cmd), 32'h1);
    chk("rl_cs",   32'(cs), 32'b001);
    #2 rst_n = 1'b0;
    #1;
    chk("rl_load_drop", 32'(load_cmd), 32'h0);
    chk("rl_cs_drop",   32'(cs), 32'h0);
    chk("rl_busy_drop", 32'(busy), 32'h0);
    chk("rl_data_drop", 32'(data), 32'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Randomized transactions with random ready, module data and clears.
    rand_ready = 1'b1;
    rand_mod   = 1'b1;
    rand_clr   = 1'b1;
    repeat (250) begin
      cmd = 8'($urandom);
      send_byte(cmd);
      if (cmd[7]) begin
        repeat ($urandom_range(0, 3)) tick();
        send_byte(8'($urandom));
      end else if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 1)) tick();
        send_byte(8'($urandom));
      end
      wait_idle(300);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_ready = 1'b0;
    rand_mod   = 1'b0;
    rand_clr   = 1'b0;
    err_clear  = 1'b0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    n_cmp++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
